image_pingpong_ctrl: RTL
========================

// Module: image_pingpong_ctrl
// PURPOSE
//  Schedules the two image buffers (m0/m1) of the image block as a ping-pong pair. Accepts
//  load (write) and compute (read) start requests, tracks per-buffer state, and issues the
//  CFG_IMG_WR / CFG_IMG_RD config words that select the buffer. Sits between the sequencer
//  and the image block cfg bus, merged onto that bus by the cfg mux.
// PARAMETERS
//  CFG_DWIDTH   32     cfg data width
//  CFG_AWIDTH   5      cfg address width
//  ADDR_IMG_WR  5'd1   cfg address of the image write-path select
//  ADDR_IMG_RD  5'd2   cfg address of the image read-path select
// PORTS
//  clk          in   1           clock
//  rst          in   1           asynchronous active-high reset
//  wr_start_val in   1           request to begin loading an image into the next free buffer
//  wr_start_rdy out  1           load request accepted when val&rdy
//  wr_done      in   1           1-cycle pulse: current load complete
//  rd_start_val in   1           request to begin streaming the next full buffer
//  rd_start_rdy out  1           compute request accepted when val&rdy
//  rd_done      in   1           1-cycle pulse: current read complete (last beat taken)
//  cfg_data     out  CFG_DWIDTH  bit0 = buffer select (0=m0, 1=m1), other bits 0
//  cfg_addr     out  CFG_AWIDTH  ADDR_IMG_WR or ADDR_IMG_RD
//  cfg_valid    out  1           1-cycle cfg write strobe, no backpressure
//  buf_state    out  4           {buf1[1:0], buf0[1:0]} state codes
//  err          out  1           sticky protocol-error flag
// BEHAVIOUR
//  - Buffer state per buffer: EMPTY=0, FILLING=1, FULL=2, DRAINING=3.
//  - Pointers wr_sel, rd_sel (1 bit each); flags wr_busy, rd_busy, wr_pend, rd_pend.
//  - Reset (async): all buffers EMPTY, pointers 0, busy/pend 0, cfg_valid 0, cfg_addr 0,
//    cfg_data 0, err 0. Reset mid-operation discards pending commands; no cfg_valid issued.
//  - wr_start_rdy = ~wr_busy & ~wr_pend & (state[wr_sel]==EMPTY); uses registered state only.
//  - Write accept: state[wr_sel]<=FILLING, wr_busy<=1, wr_pend<=1.
//  - wr_done while wr_busy: state[wr_sel]<=FULL, wr_sel toggles, wr_busy<=0.
//  - rd_start_rdy = ~rd_busy & ~rd_pend & (state[rd_sel]==FULL).
//  - Read accept: state[rd_sel]<=DRAINING, rd_busy<=1, rd_pend<=1.
//  - rd_done while rd_busy: state[rd_sel]<=EMPTY, rd_sel toggles, rd_busy<=0.
//  - Cfg issue: one word per cycle, registered. If wr_pend, issue {ADDR_IMG_WR, wr_sel} and
//    clear wr_pend; otherwise if rd_pend, issue {ADDR_IMG_RD, rd_sel} and clear rd_pend.
//    WR has priority; a pending RD issues the following cycle.
//  - Latency: accept at cycle N -> cfg_valid at N+1 (N+2 for RD losing to WR).
//  - cfg_addr/cfg_data hold their last value when cfg_valid=0.
//  - A done pulse and start request for the same pointer in one cycle: done is applied;
//    the start is not accepted, because rdy uses pre-done state. It can be accepted the
//    next cycle.
//  - wr_done and rd_done in the same cycle: both are applied, since they target
//    different buffers.
//  - wr_done with ~wr_busy, or rd_done with ~rd_busy: ignored, err<=1 (sticky until rst).
//  - A done pulse arriving while its own command is still pending is legal and is applied.
//  - Invariant: at most one buffer FILLING and at most one DRAINING; the state is never
//    FILLING and DRAINING on the same buffer.
// TESTING
//  - Reset release: wr_start_rdy=1, rd_start_rdy=0, buf_state=4'b0000, cfg_valid=0.
//  - Load m0: wr_start at cyc 1 -> cyc 2 cfg_valid, addr=1, data=0, buf_state=4'b0001.
//    Then wr_done -> buf_state=4'b0010, wr_sel=1.
//  - Overlap: read m0 while loading m1, with wr_start and rd_start accepted the same
//    cycle -> WR(data=1) is issued first and RD(data=0) the next cycle.
//    buf_state becomes 4'b0111.
//  - Full stall: both buffers FULL -> wr_start_rdy=0. rd_done on m0 -> the next cycle
//    wr_start_rdy=1 and the WR cfg selects m0.
//  - Errors: a stray wr_done while idle -> err=1 with no state change; a stray rd_done
//    also leaves the state unchanged.
//  - Async rst asserted mid-fill with a pending cfg -> outputs return to reset values
//    with no clock edge required, and no cfg_valid is issued.

Source files
------------

// File: rtl/image_pingpong_ctrl.sv
// Ping-pong scheduler for the two image buffers (m0/m1): tracks per-buffer
// fill/drain state and emits the cfg words that steer the image block.
module image_pingpong_ctrl #(
  parameter int                    CFG_DWIDTH  = 32,
  parameter int                    CFG_AWIDTH  = 5,
  parameter logic [CFG_AWIDTH-1:0] ADDR_IMG_WR = CFG_AWIDTH'(1),
  parameter logic [CFG_AWIDTH-1:0] ADDR_IMG_RD = CFG_AWIDTH'(2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_start_val,
  output logic                  wr_start_rdy,
  input  logic                  wr_done,
  input  logic                  rd_start_val,
  output logic                  rd_start_rdy,
  input  logic                  rd_done,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic                  cfg_valid,
  output logic [3:0]            buf_state,
  output logic                  err
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } buf_state_e;

  buf_state_e st_q [2];
  buf_state_e st_d [2];

  logic wr_sel_q, wr_sel_d;
  logic rd_sel_q, rd_sel_d;
  logic wr_busy_q, wr_busy_d;
  logic rd_busy_q, rd_busy_d;
  logic wr_pend_q, wr_pend_d;
  logic rd_pend_q, rd_pend_d;
  logic err_q, err_d;
  logic cfg_valid_q, cfg_valid_d;
  logic [CFG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
  logic [CFG_DWIDTH-1:0] cfg_data_q, cfg_data_d;

  logic wr_acc;
  logic rd_acc;

  // Readiness looks only at registered state, so a same-cycle done cannot open the gate.
  assign wr_start_rdy = ~wr_busy_q & ~wr_pend_q & (st_q[wr_sel_q] == EMPTY);
  assign rd_start_rdy = ~rd_busy_q & ~rd_pend_q & (st_q[rd_sel_q] == FULL);
  assign wr_acc       = wr_start_val & wr_start_rdy;
  assign rd_acc       = rd_start_val & rd_start_rdy;

  always_comb begin
    st_d[0]     = st_q[0];
    st_d[1]     = st_q[1];
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    wr_busy_d   = wr_busy_q;
    rd_busy_d   = rd_busy_q;
    wr_pend_d   = wr_pend_q;
    rd_pend_d   = rd_pend_q;
    err_d       = err_q;
    cfg_valid_d = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;

    if (wr_acc) begin
      st_d[wr_sel_q] = FILLING;
      wr_busy_d      = 1'b1;
      wr_pend_d      = 1'b1;
    end
    if (wr_done) begin
      if (wr_busy_q) begin
        st_d[wr_sel_q] = FULL;
        wr_sel_d       = ~wr_sel_q;
        wr_busy_d      = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    if (rd_acc) begin
      st_d[rd_sel_q] = DRAINING;
      rd_busy_d      = 1'b1;
      rd_pend_d      = 1'b1;
    end
    if (rd_done) begin
      if (rd_busy_q) begin
        st_d[rd_sel_q] = EMPTY;
        rd_sel_d       = ~rd_sel_q;
        rd_busy_d      = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    // A command accepted this cycle issues at this edge; WR wins, RD waits one cycle.
    if (wr_pend_q | wr_acc) begin
      cfg_valid_d = 1'b1;
      cfg_addr_d  = ADDR_IMG_WR;
      cfg_data_d  = {{(CFG_DWIDTH-1){1'b0}}, wr_sel_q};
      wr_pend_d   = 1'b0;
    end else if (rd_pend_q | rd_acc) begin
      cfg_valid_d = 1'b1;
      cfg_addr_d  = ADDR_IMG_RD;
      cfg_data_d  = {{(CFG_DWIDTH-1){1'b0}}, rd_sel_q};
      rd_pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0]     <= EMPTY;
      st_q[1]     <= EMPTY;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_busy_q   <= 1'b0;
      rd_busy_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      err_q       <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
    end else begin
      st_q[0]     <= st_d[0];
      st_q[1]     <= st_d[1];
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      wr_busy_q   <= wr_busy_d;
      rd_busy_q   <= rd_busy_d;
      wr_pend_q   <= wr_pend_d;
      rd_pend_q   <= rd_pend_d;
      err_q       <= err_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
    end
  end

  assign cfg_valid = cfg_valid_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign err       = err_q;
  assign buf_state = {st_q[1], st_q[0]};

endmodule
